rc4_skew_feeder: RTL and testbench

Operand-skew and result-deskew wrapper around the 4-bit bit-pipelined ripple-carry adder, whose carries are registered between bit slices. Accepts whole operands on a valid/ready interface and presents bit i of each operand i cycles after bit 0, so every slice sees its carry from the same transaction. Collects the staggered sum bits and final carry-out, reassembles a 5-bit result, and buffers it in an output FIFO. Because the adder pipeline cannot stall, downstream backpressure is enforced through a credit count.

---
 rtl/rc4_skew_feeder_pkg.sv | 21 ++
 rtl/rc4_skew_feeder_result_fifo.sv | 93 +++++++++
 rtl/rc4_skew_feeder.sv | 187 ++++++++++++++++++
 tb/tb_rc4_skew_feeder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_skew_feeder_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared constants and the result record for the 4-bit bit-pipelined
// ripple-carry adder wrapper (rc4_skew_feeder) and its result FIFO.
//   RC4_WIDTH      adder bit width
//   RC4_LAT        adder latency in cycles (one registered carry per slice)
//   RC4_DEPTH_MIN  smallest result FIFO that sustains one operation per cycle
//   rc4_result_t   {cout, sum} as pushed into the result FIFO
// -----------------------------------------------------------------------------
package rc4_pkg;

    localparam int RC4_WIDTH     = 4;
    localparam int RC4_LAT       = RC4_WIDTH;
    localparam int RC4_DEPTH_MIN = RC4_WIDTH + 1;

    typedef struct packed {
        logic                 cout;
        logic [RC4_WIDTH-1:0] sum;
    } rc4_result_t;

endpackage

// File: rtl/rc4_skew_feeder_result_fifo.sv
// -----------------------------------------------------------------------------
// rc4_result_fifo
// Synchronous first-word-fall-through FIFO holding reassembled adder results.
// The head entry is presented on pop_data_o while empty_o is low.
// A push together with a pop on a full FIFO is legal (both happen). The
// writer is responsible for never pushing into a full FIFO without a pop.
// There is no empty-FIFO bypass: a pushed word becomes visible on the next
// cycle.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (empties the FIFO)
//   push_i         write push_data_i at the tail
//   push_data_i    {cout, sum}
//   pop_i          drop the head entry (ignored when empty)
//   pop_data_o     head entry
//   full_o         DEPTH entries held
//   empty_o        no entries held
//   count_o        number of entries held
// -----------------------------------------------------------------------------
module rc4_result_fifo
    import rc4_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [RC4_WIDTH:0]         push_data_i,
    input  logic                       pop_i,
    output logic [RC4_WIDTH:0]         pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    rc4_result_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign do_push = push_i;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; emptiness is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/rc4_skew_feeder.sv
// -----------------------------------------------------------------------------
// rc4_skew_feeder
// Operand-skew / result-deskew wrapper around a bit-pipelined ripple-carry
// adder whose carries are registered between bit slices. Bit i of an accepted
// operand pair is driven to the adder i+1 cycles after acceptance, so every
// slice meets the carry produced by the same transaction. The staggered sum
// bits are realigned, combined with the carry-out and queued in a result FIFO.
// The adder cannot stall, so acceptance is limited by a credit counter that
// counts operations accepted but not yet popped from the FIFO.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake; in_a, in_b, in_cin operands
//   add_a, add_b, add_cin skewed operands to the adder (cin travels with bit 0)
//   add_sum, add_cout     adder outputs (cout valid with the top bit)
//   out_valid/out_ready   result handshake; out_data = {cout, sum}
// -----------------------------------------------------------------------------
module rc4_skew_feeder
    import rc4_pkg::*;
#(
    parameter int WIDTH = RC4_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_data
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             live_q;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             accept, pop;
    logic [WIDTH-1:0] a_slot, b_slot;
    logic             cin_slot;
    logic             cin_q;
    logic [WIDTH-1:0] sum_aligned;
    logic [WIDTH-1:0] vld_q;
    rc4_result_t      result;
    logic             fifo_push;
    logic [WIDTH:0]   fifo_data;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // ---------------------------------------------------------------- credits
    // live_q holds in_ready low until the first edge after reset release.
    assign in_ready = live_q && (outstanding_q < CNT_W'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept, pop})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q        <= 1'b0;
            outstanding_q <= '0;
        end else begin
            live_q        <= 1'b1;
            outstanding_q <= outstanding_d;
        end
    end

    // ------------------------------------------------------------ operand skew
    // Unaccepted slots carry zeros, which generate no carry inside the adder.
    assign a_slot   = accept ? in_a : '0;
    assign b_slot   = accept ? in_b : '0;
    assign cin_slot = accept && in_cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_skew
        logic [i:0] a_sr_q, b_sr_q;
        if (i == 0) begin : g_first
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_sr_q <= '0;
                    b_sr_q <= '0;
                end else begin
                    a_sr_q <= a_slot[i];
                    b_sr_q <= b_slot[i];
                end
            end
        end else begin : g_rest
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_sr_q <= '0;
                    b_sr_q <= '0;
                end else begin
                    a_sr_q <= {a_sr_q[i-1:0], a_slot[i]};
                    b_sr_q <= {b_sr_q[i-1:0], b_slot[i]};
                end
            end
        end
        assign add_a[i] = a_sr_q[i];
        assign add_b[i] = b_sr_q[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cin_q <= 1'b0;
        end else begin
            cin_q <= cin_slot;
        end
    end

    assign add_cin = cin_q;

    // ---------------------------------------------------------- result deskew
    // Sum bit i is valid one edge after it was driven; it is delayed by
    // WIDTH-1-i more registers so every bit lines up with the top bit,
    // which (with cout) is taken straight from the adder.
    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_deskew
        localparam int D = WIDTH - 1 - i;
        logic [D-1:0] sr_q;
        if (D == 1) begin : g_one
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= add_sum[i];
                end
            end
        end else begin : g_many
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= {sr_q[D-2:0], add_sum[i]};
                end
            end
        end
        assign sum_aligned[i] = sr_q[D-1];
    end

    assign sum_aligned[WIDTH-1] = add_sum[WIDTH-1];

    // ---------------------------------------------------------- valid pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[WIDTH-2:0], accept};
        end
    end

    assign result.cout = add_cout;
    assign result.sum  = sum_aligned;

    // Credits already prevent overflow; the full check keeps the FIFO safe
    // should the credit limit and FIFO depth ever be made to disagree.
    assign fifo_push = vld_q[WIDTH-1] && (!fifo_full || pop);

    // ---------------------------------------------------------- result FIFO
    rc4_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (result),
        .pop_i       (pop),
        .pop_data_o  (fifo_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_empty ? '0 : fifo_data;

endmodule

// File: tb/tb_rc4_skew_feeder.sv
module tb_rc4_skew_feeder;

    localparam int W     = 4;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid, in_ready, in_cin;
    logic [W-1:0] in_a, in_b;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic         out_valid, out_ready;
    logic [W:0]   out_data;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    int pop_cnt  = 0;
    logic [W:0] sb[$];

    always #5 clk = ~clk;

    rc4_skew_feeder #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Bit-pipelined ripple-carry adder: slice carries registered, sync reset.
    logic [W-1:0] carry_q, c_vec, c_out;
    assign c_vec = {carry_q[W-2:0], add_cin};

    always_comb begin
        add_sum = '0;
        c_out   = '0;
        for (int i = 0; i < W; i++) begin
            add_sum[i] = add_a[i] ^ add_b[i] ^ c_vec[i];
            c_out[i]   = (add_a[i] & add_b[i]) | (add_a[i] & c_vec[i]) | (add_b[i] & c_vec[i]);
        end
    end
    assign add_cout = c_out[W-1];

    always_ff @(posedge clk) begin
        if (rst) carry_q <= '0;
        else     carry_q <= c_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
    endtask

    // Scoreboard: inputs are stable from #1 after a rising edge, so the
    // handshakes seen on the falling edge are the ones taken at the next edge.
    always @(negedge clk) begin
        logic [W:0] exp;
        if (rst) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back((W+1)'(in_a) + (W+1)'(in_b) + (W+1)'(in_cin));
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                pop_cnt++;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_output", 32'(sb.size() != 0), 32'd1);
                end else begin
                    exp = sb.pop_front();
                    chk("sb_result", 32'(out_data), 32'(exp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic drain(input string tag);
        for (int n = 0; n < 40 && sb.size() != 0; n++) tick();
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ta[8];
        logic [W-1:0] tbv[8];
        logic         tc[8];
        logic [W-1:0] m;
        int base_pop, base_acc;

        ta  = '{4'h3, 4'hF, 4'h0, 4'h8, 4'hA, 4'h1, 4'h7, 4'hC};
        tbv = '{4'h5, 4'hF, 4'h0, 4'h8, 4'h5, 4'h2, 4'h7, 4'h3};
        tc  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        drive(0, '0, '0, 0);
        out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_add_cin", 32'(add_cin), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single op 7 + 9 + 0: operand bits appear one slice per cycle
        out_ready = 1'b1;
        drive(1, 4'h7, 4'h9, 0);
        tick();
        drive(0, '0, '0, 0);
        for (int c = 1; c <= 4; c++) begin
            m = W'(1) << (c - 1);
            chk("single_add_a", 32'(add_a), 32'(4'h7 & m));
            chk("single_add_b", 32'(add_b), 32'(4'h9 & m));
            if (c == 1) chk("single_add_cin", 32'(add_cin), 32'd0);
            chk("single_out_valid_low", 32'(out_valid), 32'd0);
            tick();
        end
        chk("single_out_valid", 32'(out_valid), 32'd1);
        chk("single_out_data", 32'(out_data), 32'h10);
        tick();

        // Back-to-back 8 ops, one result per cycle
        base_pop = pop_cnt;
        for (int k = 0; k < 8; k++) begin
            drive(1, ta[k], tbv[k], tc[k]);
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        drive(0, '0, '0, 0);
        repeat (4) tick();
        chk("b2b_pops_7", 32'(pop_cnt - base_pop), 32'd7);
        chk("b2b_out_valid", 32'(out_valid), 32'd1);
        tick();
        chk("b2b_pops_8", 32'(pop_cnt - base_pop), 32'd8);
        chk("b2b_out_valid_done", 32'(out_valid), 32'd0);

        // Backpressure: 10 offered, exactly 8 accepted
        out_ready = 1'b0;
        base_acc = acc_cnt;
        for (int k = 0; k < 10; k++) begin
            drive(1, W'(k), W'(k * 3), 1'(k & 1));
            tick();
        end
        chk("bp_accepted", 32'(acc_cnt - base_acc), 32'd8);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        repeat (3) tick();
        chk("bp_in_ready_still_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_head", 32'(out_data), 32'h00);

        // Full FIFO with in_valid and out_ready together
        out_ready = 1'b1;
        drive(1, 4'h6, 4'h6, 1);
        tick();
        chk("full_no_accept_first", 32'(acc_cnt - base_acc), 32'd8);
        chk("full_in_ready_reassert", 32'(in_ready), 32'd1);
        for (int k = 0; k < 12; k++) begin
            drive(1, W'($urandom_range(15)), W'($urandom_range(15)), 1'($urandom_range(1)));
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            chk("stream_out_valid", 32'(out_valid), 32'd1);
            tick();
        end
        drive(0, '0, '0, 0);
        drain("stream_drain");

        // Reset mid-flight
        drive(1, 4'h2, 4'h3, 0);
        tick();
        drive(1, 4'h5, 4'h6, 1);
        tick();
        drive(1, 4'h9, 4'h9, 0);
        tick();
        drive(0, '0, '0, 0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_add_a", 32'(add_a), 32'd0);
        chk("midrst_add_b", 32'(add_b), 32'd0);
        chk("midrst_add_cin", 32'(add_cin), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        drive(1, 4'h1, 4'h1, 0);
        tick();
        drive(0, '0, '0, 0);
        repeat (4) tick();
        chk("midrst_out_valid_new", 32'(out_valid), 32'd1);
        chk("midrst_out_data", 32'(out_data), 32'h02);
        drain("midrst_drain");

        // Skew isolation: carry of (F,0,1) must not reach the following op
        drive(1, 4'hF, 4'h0, 1);
        tick();
        drive(1, 4'h0, 4'h0, 0);
        tick();
        drive(0, '0, '0, 0);
        repeat (3) tick();
        chk("iso_first_valid", 32'(out_valid), 32'd1);
        chk("iso_first_data", 32'(out_data), 32'h10);
        tick();
        chk("iso_second_valid", 32'(out_valid), 32'd1);
        chk("iso_second_data", 32'(out_data), 32'h00);
        drain("iso_drain");
        tick();
        chk("final_out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
